// File: rtl/cache_tag_assoc.sv
// N-way set-associative tag store with per-set tree pseudo-LRU and a sequential flush walk.
// Lookup and victim selection are combinational; all state updates happen on the rising clock edge.
module cache_tag_assoc #(
   parameter int unsigned NUM_SETS = 512,
   parameter int unsigned NUM_WAYS = 4,
   parameter int unsigned TAG_W    = 18,
   parameter int unsigned INDEX_W  = $clog2(NUM_SETS),
   parameter int unsigned WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   output logic               ready_o,
   input  logic               req_valid_i,
   input  logic [INDEX_W-1:0] req_index_i,
   input  logic [TAG_W-1:0]   req_tag_i,
   input  logic               req_we_i,
   input  logic [WAY_W-1:0]   req_way_i,
   input  logic               req_vbit_i,
   input  logic               req_dirty_i,
   output logic               hit_o,
   output logic [WAY_W-1:0]   hit_way_o,
   output logic [WAY_W-1:0]   victim_way_o,
   output logic [TAG_W-1:0]   victim_tag_o,
   output logic               victim_valid_o,
   output logic               victim_dirty_o
);

   localparam int unsigned LEVELS = $clog2(NUM_WAYS);
   localparam int unsigned PLRU_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

   typedef enum logic [0:0] {StFlush, StIdle} state_e;

   state_e             state_q, state_d;
   logic [INDEX_W-1:0] cnt_q, cnt_d;

   logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
   logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
   logic [PLRU_W-1:0]   plru_q  [NUM_SETS];

   logic [NUM_WAYS-1:0] set_valid, set_dirty, match;
   logic [PLRU_W-1:0]   set_plru, plru_upd;
   logic                hit_any;
   logic [WAY_W-1:0]    hit_way, vic_way, touch_way;

   // ---------------------------------------------------------------- control FSM
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StFlush: begin
            cnt_d = cnt_q + INDEX_W'(1);
            if (cnt_q == INDEX_W'(NUM_SETS - 1)) state_d = StIdle;
         end
         StIdle: begin
            if (flush_i) begin
               state_d = StFlush;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = StFlush;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StFlush;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ready_o = (state_q == StIdle);

   // ---------------------------------------------------------------- lookup
   assign set_valid = valid_q[req_index_i];
   assign set_dirty = dirty_q[req_index_i];
   assign set_plru  = plru_q[req_index_i];

   always_comb begin
      match = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         match[w] = set_valid[w] && (tag_q[req_index_i][w] == req_tag_i);
      end
   end

   assign hit_any = |match;

   always_comb begin
      hit_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (match[w]) hit_way = WAY_W'(w);
      end
   end

   assign hit_o     = req_valid_i && ready_o && hit_any;
   assign hit_way_o = hit_o ? hit_way : '0;

   // ---------------------------------------------------------------- victim selection
   always_comb begin : victim_sel
      logic              found;
      int                node;
      int                acc;
      logic [PLRU_W-1:0] sh;
      vic_way = '0;
      found   = 1'b0;
      node    = 0;
      acc     = 0;
      sh      = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!found && !set_valid[w]) begin
            vic_way = WAY_W'(w);
            found   = 1'b1;
         end
      end
      // Tree bit 1 means the older half is on the right.
      if (!found) begin
         for (int l = 0; l < LEVELS; l++) begin
            sh   = set_plru >> node;
            acc  = acc * 2 + int'(sh[0]);
            node = 2 * node + 1 + int'(sh[0]);
         end
         vic_way = WAY_W'(acc);
      end
   end

   assign victim_way_o   = ready_o ? vic_way : '0;
   assign victim_tag_o   = ready_o ? tag_q[req_index_i][vic_way] : '0;
   assign victim_valid_o = ready_o ? set_valid[vic_way] : 1'b0;
   assign victim_dirty_o = ready_o ? set_dirty[vic_way] : 1'b0;

   // ---------------------------------------------------------------- PLRU update
   assign touch_way = req_we_i ? req_way_i : hit_way;

   always_comb begin : plru_next
      int                node;
      int                dir;
      logic [PLRU_W-1:0] mask;
      plru_upd = set_plru;
      node     = 0;
      dir      = 0;
      mask     = '0;
      for (int l = 0; l < LEVELS; l++) begin
         node = (1 << l) - 1 + (int'(touch_way) >> (LEVELS - l));
         dir  = (int'(touch_way) >> (LEVELS - 1 - l)) & 1;
         mask = PLRU_W'(1) << node;
         if (dir == 0) plru_upd = plru_upd | mask;
         else          plru_upd = plru_upd & ~mask;
      end
   end

   // ---------------------------------------------------------------- storage
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (state_q == StFlush) begin
            valid_q[cnt_q] <= '0;
            dirty_q[cnt_q] <= '0;
            plru_q[cnt_q]  <= '0;
         end else if (req_valid_i) begin
            if (req_we_i) begin
               tag_q[req_index_i][req_way_i]   <= req_tag_i;
               valid_q[req_index_i][req_way_i] <= req_vbit_i;
               dirty_q[req_index_i][req_way_i] <= req_dirty_i;
            end
            if (req_we_i || hit_any) plru_q[req_index_i] <= plru_upd;
         end
      end
   end

endmodule

// File: tb/tb_cache_tag_assoc.sv
// Directed and randomized bench for cache_tag_assoc against an interval-based tree-PLRU model.
module tb_cache_tag_assoc;

   localparam int NS = 8;
   localparam int NW = 4;
   localparam int TW = 8;
   localparam int IW = 3;
   localparam int WW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, flush, rv, we, vbit, dirty;
   logic [IW-1:0] idx;
   logic [TW-1:0] tag;
   logic [WW-1:0] way;
   logic          ready, hit, vvalid, vdirty;
   logic [WW-1:0] hway, vway;
   logic [TW-1:0] vtag;

   cache_tag_assoc #(
      .NUM_SETS(NS),
      .NUM_WAYS(NW),
      .TAG_W   (TW)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .flush_i       (flush),
      .ready_o       (ready),
      .req_valid_i   (rv),
      .req_index_i   (idx),
      .req_tag_i     (tag),
      .req_we_i      (we),
      .req_way_i     (way),
      .req_vbit_i    (vbit),
      .req_dirty_i   (dirty),
      .hit_o         (hit),
      .hit_way_o     (hway),
      .victim_way_o  (vway),
      .victim_tag_o  (vtag),
      .victim_valid_o(vvalid),
      .victim_dirty_o(vdirty)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference model: plain arrays, PLRU as a 1-based heap of "older half is right" bits.
   int m_tag  [NS][NW];
   bit m_v    [NS][NW];
   bit m_d    [NS][NW];
   bit m_plru [NS][2*NW];
   int flush_left = 0;

   bit e_ready, e_hit, e_vvalid, e_vdirty;
   int e_hway, e_vway, e_vtag;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic compute_expected();
      int i, lo, hi, mid, node;
      i        = int'(idx);
      e_ready  = (flush_left == 0);
      e_hit    = 1'b0;
      e_hway   = 0;
      e_vway   = 0;
      e_vvalid = 1'b0;
      e_vdirty = 1'b0;
      e_vtag   = 0;
      if (e_ready && rv) begin
         for (int w = NW - 1; w >= 0; w--) begin
            if (m_v[i][w] && m_tag[i][w] == int'(tag)) begin
               e_hit  = 1'b1;
               e_hway = w;
            end
         end
      end
      if (e_ready) begin
         e_vway = -1;
         for (int w = 0; w < NW; w++) if (e_vway < 0 && !m_v[i][w]) e_vway = w;
         if (e_vway < 0) begin
            lo = 0; hi = NW; node = 1;
            while (hi - lo > 1) begin
               mid = (lo + hi) / 2;
               if (m_plru[i][node]) begin lo = mid; node = 2 * node + 1; end
               else begin hi = mid; node = 2 * node; end
            end
            e_vway = lo;
         end
         e_vvalid = m_v[i][e_vway];
         e_vdirty = m_d[i][e_vway];
         e_vtag   = m_tag[i][e_vway];
      end
   endtask

   task automatic touch(input int i, input int w);
      int lo, hi, mid, node;
      lo = 0; hi = NW; node = 1;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (w < mid) begin m_plru[i][node] = 1'b1; hi = mid; node = 2 * node; end
         else begin m_plru[i][node] = 1'b0; lo = mid; node = 2 * node + 1; end
      end
   endtask

   // Apply this cycle's effects to the model, then advance to the next sampling point.
   task automatic tick();
      int i, s;
      i = int'(idx);
      compute_expected();
      if (rst) begin
         flush_left = NS;
      end else if (flush_left > 0) begin
         s = NS - flush_left;
         for (int w = 0; w < NW; w++) begin m_v[s][w] = 1'b0; m_d[s][w] = 1'b0; end
         for (int n = 0; n < 2 * NW; n++) m_plru[s][n] = 1'b0;
         flush_left--;
      end else begin
         if (rv && we) begin
            m_tag[i][way] = int'(tag);
            m_v[i][way]   = vbit;
            m_d[i][way]   = dirty;
         end
         if (rv && (we || e_hit)) touch(i, we ? int'(way) : e_hway);
         if (flush) flush_left = NS;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all();
      compute_expected();
      check("ready", ready, e_ready);
      check("hit", hit, e_hit);
      check("hit_way", hway, e_hway);
      check("victim_way", vway, e_vway);
      check("victim_valid", vvalid, e_vvalid);
      check("victim_dirty", vdirty, e_vdirty);
      if (e_vvalid) check("victim_tag", vtag, e_vtag);
   endtask

   task automatic idle();
      rst = 0; flush = 0; rv = 0; we = 0; vbit = 0; dirty = 0;
      idx = '0; tag = '0; way = '0;
   endtask

   task automatic wr(input int i, input int w, input int t, input bit v, input bit d);
      rv = 1; we = 1; idx = IW'(i); way = WW'(w); tag = TW'(t); vbit = v; dirty = d;
   endtask

   task automatic rd(input int i, input int t);
      rv = 1; we = 0; idx = IW'(i); tag = TW'(t);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      @(negedge clk);

      // Reset, then exactly NS cycles of flushing.
      rst = 1;
      tick();
      rst = 0;
      for (int c = 0; c < NS; c++) begin
         #1 check("reset_busy", ready, 1'b0);
         check("reset_busy_hit", hit, 1'b0);
         tick();
      end
      #1 check("reset_ready", ready, 1'b1);
      for (int s = 0; s < NS; s++) begin
         rd(s, $urandom_range(0, 255));
         #1 check("post_reset_hit", hit, 1'b0);
         check("post_reset_victim", vway, 0);
         check_all();
      end

      // Single write, read-during-write shows old contents.
      wr(3, 2, 8'hA5, 1, 0);
      #1 check("rdw_old", hit, 1'b0);
      tick();
      rd(3, 8'hA5);
      #1 check("hit_a5", hit, 1'b1);
      check("hit_way_a5", hway, 2);
      rd(3, 8'hA4);
      #1 check("miss_a4", hit, 1'b0);
      check_all();

      // Fill a set, touch ways 0 and 2, PLRU should point at way 1.
      for (int w = 0; w < NW; w++) begin
         wr(5, w, 8'h10 + w, 1, 0);
         tick();
      end
      rd(5, 8'h10);
      #1 check("hit_w0", hway, 0);
      tick();
      rd(5, 8'h12);
      #1 check("hit_w2", hway, 2);
      tick();
      rv = 0;
      #1 check("plru_victim", vway, 1);
      check("plru_victim_tag", vtag, 8'h11);
      check("plru_victim_valid", vvalid, 1'b1);
      check_all();

      // Dirty line then invalidate it.
      wr(1, 0, 8'h33, 1, 1);
      tick();
      rd(1, 8'h33);
      #1 check("dirty_victim_first_invalid", vway, 1);
      wr(1, 0, 8'h33, 0, 0);
      tick();
      rd(1, 8'h33);
      #1 check("inval_victim", vway, 0);
      check("inval_victim_valid", vvalid, 1'b0);
      check("inval_miss", hit, 1'b0);

      // Flush request with a simultaneous write; writes during flush dropped.
      wr(2, 1, 8'h77, 1, 0);
      tick();
      wr(6, 0, 8'h66, 1, 1);
      flush = 1;
      #1 check("flush_cycle_ready", ready, 1'b1);
      tick();
      flush = 0;
      wr(4, 3, 8'h44, 1, 1);
      for (int c = 0; c < NS; c++) begin
         #1 check("flush_busy", ready, 1'b0);
         check("flush_busy_victim", vway, 0);
         tick();
      end
      #1 check("flush_done", ready, 1'b1);
      rd(2, 8'h77);
      #1 check("flushed_idx2", hit, 1'b0);
      rd(4, 8'h44);
      #1 check("dropped_write", hit, 1'b0);
      rd(6, 8'h66);
      #1 check("flushed_idx6", hit, 1'b0);
      check_all();

      // Reset while counter = 4 restarts the walk.
      idle();
      flush = 1;
      tick();
      flush = 0;
      for (int c = 0; c < 4; c++) tick();
      rst = 1;
      #1 check("midflush_busy", ready, 1'b0);
      tick();
      rst = 0;
      for (int c = 0; c < NS; c++) begin
         #1 check("restart_busy", ready, 1'b0);
         tick();
      end
      #1 check("restart_ready", ready, 1'b1);

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         rst   = ($urandom_range(0, 199) == 0);
         flush = ($urandom_range(0, 59) == 0);
         rv    = ($urandom_range(0, 9) != 0);
         we    = ($urandom_range(0, 2) == 0);
         vbit  = ($urandom_range(0, 4) != 0);
         dirty = 1'($urandom_range(0, 1));
         idx   = IW'($urandom_range(0, NS - 1));
         way   = WW'($urandom_range(0, NW - 1));
         tag   = TW'($urandom_range(0, 5));
         #1 check_all();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
